// File: rtl/inst_dispatcher_if.sv
// Host-to-dispatcher instruction bus: enqueue handshake plus the
// dispatcher's issue-side outputs and status.
interface inst_dispatcher_if #(
    parameter int INST_BITS  = 148,
    parameter int LEVEL_BITS = 5
);
    logic                  s_valid;
    logic                  s_ready;
    logic [INST_BITS-1:0]  s_inst;
    logic [INST_BITS-1:0]  instruction;
    logic                  issue;
    logic                  busy;
    logic                  err_illegal;
    logic [LEVEL_BITS-1:0] q_level;

    modport master (
        output s_valid, s_inst,
        input  s_ready, instruction, issue, busy, err_illegal, q_level
    );

    modport slave (
        input  s_valid, s_inst,
        output s_ready, instruction, issue, busy, err_illegal, q_level
    );
endinterface

// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: queues host instructions in a FIFO and presents
// each one to the control unit for the number of cycles its opcode needs.
// Illegal opcodes are issued as a one-cycle all-zero instruction and set a
// sticky error flag.
// Optional: define DISPATCH_PERF_CNT_EN to add issued_cnt / stall_cnt.
module inst_dispatcher #(
    parameter int OPCODE_BITS             = 4,
    parameter int ADDR_BITS               = 8,
    parameter int OPERAND_BITS            = 128,
    parameter int FIFO_DEPTH              = 16,
    parameter int IDLE_CYCLE              = 1,
    parameter int AXI_TO_UB_CYCLE         = 1,
    parameter int AXI_TO_WB_CYCLE         = 1,
    parameter int UB_TO_DATA_FIFO_CYCLE   = 2,
    parameter int UB_TO_WEIGHT_FIFO_CYCLE = 2,
    parameter int MAT_MUL_CYCLE           = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    inst_dispatcher_if.slave   bus
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]        issued_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int INST_BITS = OPCODE_BITS + 2 * ADDR_BITS + OPERAND_BITS;
    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS  = PTR_BITS + 1;
    localparam logic [LVL_BITS-1:0] FULL_LVL = LVL_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {EMPTY, ISSUE, HOLD} state_t;

    logic [INST_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_BITS-1:0]    level_q, level_d;
    state_t                 state_q, state_d;
    logic [INST_BITS-1:0]   inst_q, inst_d;
    logic                   issue_q, issue_d;
    logic                   err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   ready;
    logic                   enq;
    logic                   deq;
    logic                   hold_done;
    logic [INST_BITS-1:0]   head;
    logic [OPCODE_BITS-1:0] head_op;
    logic                   head_legal;

    // Cycles each legal opcode occupies the instruction output.
    function automatic logic [7:0] op_cycles(input logic [OPCODE_BITS-1:0] op);
        case (int'(op))
            0:       return 8'(IDLE_CYCLE);
            1:       return 8'(AXI_TO_UB_CYCLE);
            2:       return 8'(AXI_TO_WB_CYCLE);
            3:       return 8'(UB_TO_DATA_FIFO_CYCLE);
            4:       return 8'(UB_TO_WEIGHT_FIFO_CYCLE);
            5, 6:    return 8'(MAT_MUL_CYCLE);
            default: return 8'd1;
        endcase
    endfunction

    assign ready      = (level_q < FULL_LVL);
    assign enq        = bus.s_valid && ready;
    assign hold_done  = (state_q != EMPTY) && (cnt_q == 8'd0);
    assign deq        = (level_q != '0) && ((state_q == EMPTY) || hold_done);
    assign head       = mem_q[rd_ptr_q];
    assign head_op    = head[INST_BITS-1 -: OPCODE_BITS];
    assign head_legal = (int'(head_op) <= 6);

    // Next-state: dequeue/issue, hold countdown, queue pointers and level.
    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        issue_d  = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = ISSUE;
            issue_d  = 1'b1;
            if (head_legal) begin
                inst_d = head;
                cnt_d  = op_cycles(head_op) - 8'd1;
            end else begin
                // Illegal opcode: one cycle of IDLE in its place.
                inst_d = '0;
                cnt_d  = 8'd0;
                err_d  = 1'b1;
            end
        end else if ((state_q == EMPTY) || hold_done) begin
            state_d = EMPTY;
            inst_d  = '0;
            cnt_d   = 8'd0;
        end else begin
            state_d = HOLD;
            cnt_d   = cnt_q - 8'd1;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({enq, deq})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Dispatcher FSM, registered outputs and queue control state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            inst_q   <= '0;
            issue_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            issue_q  <= issue_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Queue storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= bus.s_inst;
        end
    end

    assign bus.s_ready     = ready;
    assign bus.instruction = inst_q;
    assign bus.issue       = issue_q;
    assign bus.err_illegal = err_q;
    assign bus.q_level     = level_q;
    assign bus.busy        = (state_q != EMPTY) || (level_q != '0);

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] issued_cnt_q, issued_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running wrap-around counters of issues and refused host cycles.
    always_comb begin
        issued_cnt_d = issued_cnt_q + {31'd0, deq};
        stall_cnt_d  = stall_cnt_q + {31'd0, (bus.s_valid && !ready)};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issued_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif
endmodule
